// File: rtl/prog_nfa_pkg.sv
// Shared types and config-word map for the programmable NFA engine.
package prog_nfa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE, HALT} fsm_e;
  typedef enum logic [1:0] {ST_NONE, ST_SOD, ST_ALL} start_e;

  localparam logic [2:0] CFG_W_FLAGS  = 3'd0;
  localparam logic [2:0] CFG_W_EDGE   = 3'd1;
  localparam logic [2:0] CFG_W_RANGE0 = 3'd2;

  localparam int MAX_SYM_W = 16;

  // Inclusive unsigned range test; lo > hi naturally never matches.
  function automatic logic in_range(input logic [MAX_SYM_W-1:0] sym,
                                    input logic [MAX_SYM_W-1:0] lo,
                                    input logic [MAX_SYM_W-1:0] hi);
    return (lo <= sym) && (sym <= hi);
  endfunction

endpackage

// File: rtl/prog_nfa_range_match.sv
// Combinational symbol classifier for one STE: OR of enabled inclusive ranges.
module prog_nfa_range_match
  import prog_nfa_pkg::*;
#(
  parameter int SYM_W      = 8,
  parameter int NUM_RANGES = 4
) (
  input  logic [SYM_W-1:0]            sym_i,
  input  logic [NUM_RANGES-1:0]       en_i,
  input  logic [NUM_RANGES*SYM_W-1:0] lo_i,
  input  logic [NUM_RANGES*SYM_W-1:0] hi_i,
  output logic                        match_o
);

  always_comb begin
    match_o = 1'b0;
    for (int r = 0; r < NUM_RANGES; r++) begin
      if (en_i[r] && in_range(MAX_SYM_W'(sym_i),
                              MAX_SYM_W'(lo_i[r*SYM_W +: SYM_W]),
                              MAX_SYM_W'(hi_i[r*SYM_W +: SYM_W]))) begin
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_nfa_engine.sv
// Runtime-programmable homogeneous NFA; one symbol per accepted beat, reports registered 1 cycle later.
// Accepts beats only in RUN; optional position counters under PROG_NFA_POS_TRACK_EN.
module prog_nfa_engine
  import prog_nfa_pkg::*;
#(
  parameter int  NUM_STE        = 16,
  parameter int  SYM_W          = 8,
  parameter int  NUM_RANGES     = 4,
  parameter int  HALT_ON_REPORT = 0,
  localparam int STE_W          = (NUM_STE > 1) ? $clog2(NUM_STE) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we_i,
  input  logic [STE_W-1:0]   cfg_ste_i,
  input  logic [2:0]         cfg_word_i,
  input  logic [31:0]        cfg_wdata_i,
  input  logic               go_i,
  input  logic               stop_i,
  input  logic               sym_valid_i,
  output logic               sym_ready_o,
  input  logic [SYM_W-1:0]   sym_data_i,
  input  logic               sym_last_i,
  output logic [NUM_STE-1:0] report_o,
  output logic               report_valid_o,
  output logic               busy_o,
  output logic               halted_o
`ifdef PROG_NFA_POS_TRACK_EN
  ,
  output logic [31:0]        sym_pos_o,
  output logic [31:0]        first_rpt_pos_o
`endif
);

  localparam int RW = NUM_RANGES * SYM_W;

  logic [NUM_STE-1:0]    rpt_en_q;
  logic [1:0]            stype_q [NUM_STE];
  logic [NUM_STE-1:0]    edge_q  [NUM_STE];
  logic [NUM_RANGES-1:0] ren_q   [NUM_STE];
  logic [RW-1:0]         lo_q    [NUM_STE];
  logic [RW-1:0]         hi_q    [NUM_STE];

  fsm_e               state_q;
  logic [NUM_STE-1:0] active_q;
  logic [NUM_STE-1:0] report_q;
  logic               report_valid_q;
  logic               sod_q;
  logic               sym_ready_q;
  logic               busy_q;
  logic               halted_q;

  logic [NUM_STE-1:0] en_vec;
  logic [NUM_STE-1:0] match_vec;
  logic [NUM_STE-1:0] active_d;
  logic [NUM_STE-1:0] report_d;
  logic               beat;
  logic               rpt_hit;
  logic               cfg_ok;
  logic               unused_cfg_bits;

  assign beat            = sym_valid_i && sym_ready_q;
  assign cfg_ok          = cfg_we_i && (state_q == IDLE);
  assign unused_cfg_bits = ^cfg_wdata_i;

  // Configuration register file; writes outside IDLE are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_en_q <= '0;
      for (int j = 0; j < NUM_STE; j++) begin
        stype_q[j] <= '0;
        edge_q[j]  <= '0;
        ren_q[j]   <= '0;
        lo_q[j]    <= '0;
        hi_q[j]    <= '0;
      end
    end else if (cfg_ok) begin
      for (int j = 0; j < NUM_STE; j++) begin
        if (cfg_ste_i == STE_W'(j)) begin
          if (cfg_word_i == CFG_W_FLAGS) begin
            rpt_en_q[j] <= cfg_wdata_i[2];
            stype_q[j]  <= cfg_wdata_i[1:0];
          end
          if (cfg_word_i == CFG_W_EDGE) begin
            edge_q[j] <= cfg_wdata_i[NUM_STE-1:0];
          end
          for (int r = 0; r < NUM_RANGES; r++) begin
            if (int'(cfg_word_i) == int'(CFG_W_RANGE0) + r) begin
              ren_q[j][r]               <= cfg_wdata_i[31];
              lo_q[j][r*SYM_W +: SYM_W] <= cfg_wdata_i[SYM_W-1:0];
              hi_q[j][r*SYM_W +: SYM_W] <= cfg_wdata_i[SYM_W+15:16];
            end
          end
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_STE; j++) begin : g_ste
    prog_nfa_range_match #(
      .SYM_W     (SYM_W),
      .NUM_RANGES(NUM_RANGES)
    ) u_match (
      .sym_i  (sym_data_i),
      .en_i   (ren_q[j]),
      .lo_i   (lo_q[j]),
      .hi_i   (hi_q[j]),
      .match_o(match_vec[j])
    );
  end

  always_comb begin
    en_vec = '0;
    for (int j = 0; j < NUM_STE; j++) begin
      en_vec[j] = (|(active_q & edge_q[j])) ||
                  (stype_q[j] == ST_ALL) ||
                  ((stype_q[j] == ST_SOD) && sod_q);
    end
    active_d = en_vec & match_vec;
    report_d = active_d & rpt_en_q;
  end

  assign rpt_hit = |report_d;

  // Control FSM with the active vector and report register; stop overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      active_q       <= '0;
      sod_q          <= 1'b0;
      sym_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      report_q       <= '0;
      report_valid_q <= 1'b0;
    end else begin
      report_q       <= '0;
      report_valid_q <= 1'b0;
      if (stop_i) begin
        state_q     <= IDLE;
        active_q    <= '0;
        sod_q       <= 1'b0;
        sym_ready_q <= 1'b0;
        busy_q      <= 1'b0;
        halted_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE, HALT: begin
            if (go_i) begin
              state_q     <= RUN;
              active_q    <= '0;
              sod_q       <= 1'b1;
              sym_ready_q <= 1'b1;
              busy_q      <= 1'b1;
              halted_q    <= 1'b0;
            end
          end
          RUN: begin
            if (beat) begin
              active_q       <= active_d;
              sod_q          <= 1'b0;
              report_q       <= report_d;
              report_valid_q <= rpt_hit;
              if (sym_last_i || (rpt_hit && (HALT_ON_REPORT != 0))) begin
                state_q     <= sym_last_i ? DONE : HALT;
                sym_ready_q <= 1'b0;
                busy_q      <= 1'b0;
                halted_q    <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sym_ready_o    = sym_ready_q;
  assign report_o       = report_q;
  assign report_valid_o = report_valid_q;
  assign busy_o         = busy_q;
  assign halted_o       = halted_q;

`ifdef PROG_NFA_POS_TRACK_EN
  logic [31:0] sym_pos_q;
  logic [31:0] first_rpt_pos_q;

  // Position index of a beat is the count of beats accepted before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_pos_q       <= '0;
      first_rpt_pos_q <= '1;
    end else if (!stop_i && go_i && (state_q != RUN)) begin
      sym_pos_q       <= '0;
      first_rpt_pos_q <= '1;
    end else if (!stop_i && beat) begin
      if (sym_pos_q != '1) begin
        sym_pos_q <= sym_pos_q + 32'd1;
      end
      if (rpt_hit && (first_rpt_pos_q == '1)) begin
        first_rpt_pos_q <= sym_pos_q;
      end
    end
  end

  assign sym_pos_o       = sym_pos_q;
  assign first_rpt_pos_o = first_rpt_pos_q;
`endif

endmodule
